// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage load/store controller over a req/ready data memory; MEM_TIMEOUT_EN adds a BUSY timeout abort.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic        memtoreg_in,
  input  logic        regwrite_in,
  input  logic [31:0] aluout_in,
  input  logic [31:0] writedata_in,
  input  logic [4:0]  destReg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic        memtoreg_out,
  output logic        regwrite_out,
  output logic [31:0] aluout_out,
  output logic [31:0] readdata_out,
  output logic [4:0]  destReg_out,
  output logic        mem_err
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state_q, state_d;
  logic        mtr_q, mtr_d, rw_q, rw_d, ld_q, ld_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  dst_q, dst_d;
  logic        req_q, req_d, we_q, we_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        memop, accept, done, pass, timeout;
  assign memop  = valid_in & (memread_in | memwrite_in);
  assign accept = state_q == IDLE && memop;
  assign done   = state_q == BUSY && dmem_ready;
  assign pass   = state_q == IDLE && valid_in && !memop;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign timeout = state_q == BUSY && !dmem_ready && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign cnt_d   = (state_q == BUSY && !dmem_ready) ? cnt_q + 1'b1 : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    mtr_d   = mtr_q;
    rw_d    = rw_q;
    ld_d    = ld_q;
    alu_d   = alu_q;
    dst_d   = dst_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = timeout;
    if (accept) begin
      state_d = BUSY;
      mtr_d   = memtoreg_in;
      rw_d    = regwrite_in;
      ld_d    = memread_in & ~memwrite_in;
      alu_d   = aluout_in;
      dst_d   = destReg_in;
      req_d   = 1'b1;
      we_d    = memwrite_in;
      addr_d  = {aluout_in[31:2], 2'b00};
      wdata_d = writedata_in;
    end else if (done || timeout) begin
      state_d = IDLE;
      req_d   = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      mtr_q   <= 1'b0;
      rw_q    <= 1'b0;
      ld_q    <= 1'b0;
      alu_q   <= '0;
      dst_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mtr_q   <= mtr_d;
      rw_q    <= rw_d;
      ld_q    <= ld_d;
      alu_q   <= alu_d;
      dst_q   <= dst_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign mem_err    = err_q;
  // Outputs are forced quiet while reset is held, even though the FSM is already IDLE.
  always_comb begin
    stall_out    = !reset && (accept || (state_q == BUSY && !dmem_ready));
    regwrite_out = !reset && (pass ? regwrite_in : done && rw_q);
    memtoreg_out = !reset && (pass ? memtoreg_in : done && mtr_q);
    aluout_out   = reset ? '0 : pass ? aluout_in : done ? alu_q : '0;
    destReg_out  = reset ? '0 : pass ? destReg_in : done ? dst_q : '0;
    readdata_out = (!reset && done && ld_q) ? dmem_rdata : '0;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage controller of the pipelined MIPS core; sits between the EX/MEM register and the MEM/WB register.
- Producer side of the MEM/WB interface: generates the memtoreg/regwrite/aluout/readdata/destReg values that the MEM/WB register latches.
- Runs loads and stores against a variable-latency data memory over a req/ready handshake.
- Stalls the upstream pipeline and inserts writeback bubbles until each access completes.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in BUSY before an abort. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- valid_in  input  1  EX/MEM holds a real instruction
- memread_in  input  1  instruction is a load
- memwrite_in  input  1  instruction is a store
- memtoreg_in  input  1  writeback selects memory data
- regwrite_in  input  1  instruction writes the register file
- aluout_in  input  32  ALU result; also the memory address
- writedata_in  input  32  store data
- destReg_in  input  5  destination register
- dmem_req  output  1  memory request, registered
- dmem_we  output  1  1 = write, 0 = read
- dmem_addr  output  32  word address {addr[31:2],2'b00}
- dmem_wdata  output  32  store data
- dmem_ready  input  1  access complete this cycle
- dmem_rdata  input  32  load data, valid when dmem_ready=1
- stall_out  output  1  freeze PC, IF/ID, ID/EX and EX/MEM
- memtoreg_out  output  1  to MEM/WB memtoreg_in
- regwrite_out  output  1  to MEM/WB regwrite_in
- aluout_out  output  32  to MEM/WB aluout_in
- readdata_out  output  32  to MEM/WB readdata_in
- destReg_out  output  5  to MEM/WB destReg_in
- mem_err  output  1  one-cycle pulse on timeout abort

Behaviour:
- States: IDLE and BUSY. memop = valid_in & (memread_in | memwrite_in).
- Reset (asynchronous, active-high):
  - State goes to IDLE; hold registers, dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_err and the timeout counter all go to 0.
  - While reset is high, stall_out=0, regwrite_out=0, memtoreg_out=0 and all data outputs are 0.
- IDLE, valid_in=1, memop=0: pure pass-through. Outputs equal the inputs; readdata_out=0; stall_out=0.
- IDLE, valid_in=0: bubble. regwrite_out=0, memtoreg_out=0, data outputs 0.
- IDLE, memop=1:
  - Combinational outputs this cycle: stall_out=1, bubble on the writeback outputs.
  - At the clock edge: capture memtoreg, regwrite, aluout, destReg and memread into hold registers; load dmem_addr, dmem_we=memwrite_in and dmem_wdata; set dmem_req=1; go to BUSY.
  - If memread_in and memwrite_in are both 1, the access is treated as a store.
- BUSY, dmem_ready=0:
  - stall_out=1, bubble outputs.
  - dmem_req, dmem_addr, dmem_we and dmem_wdata are held stable.
- BUSY, dmem_ready=1:
  - Combinational: stall_out=0; outputs present the held control bits, held aluout and held destReg.
  - readdata_out = dmem_rdata for a load, 0 for a store.
  - At the edge: dmem_req goes to 0 and the state returns to IDLE.
- Latency: one memory op occupies at least 2 cycles (accept cycle + ready cycle). A zero-wait memory gives 1 stall cycle.
- Back-to-back memory ops: the next op is accepted in the IDLE cycle that follows completion. dmem_req is low for exactly one cycle between requests.
- dmem_ready while IDLE is ignored.
- Reset during BUSY: the access is aborted, dmem_req drops immediately, and no writeback is produced.
- aluout_in[1:0] are dropped on dmem_addr but preserved on aluout_out. No misalignment trap.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to BUSY and increments every BUSY cycle without dmem_ready.
  - When it reaches TIMEOUT_CYCLES without ready, at that edge: return to IDLE, drop dmem_req, pulse mem_err=1 for the next cycle.
  - The aborted instruction produces a bubble (regwrite_out=0), and stall_out is 0 in the cycle after the abort.
  - dmem_ready in the same cycle the count reaches TIMEOUT_CYCLES completes the access normally; no error.
- Disabled: mem_err tied 0; no counter; BUSY waits indefinitely.

Test Plan:
- ALU op: valid_in=1, regwrite_in=1, aluout_in=0x0000_0042, destReg_in=5 -> same cycle regwrite_out=1, aluout_out=0x42, destReg_out=5, stall_out=0, dmem_req stays 0.
- Load, memory with 3-cycle wait: memread_in=1, aluout_in=0x0000_1006, destReg_in=9 -> dmem_addr=0x1004 and dmem_we=0. Then:
  - stall_out=1 for 4 cycles (1 accept + 3 wait).
  - In the ready cycle, dmem_rdata=0xDEADBEEF gives readdata_out=0xDEADBEEF, memtoreg_out=1, destReg_out=9, stall_out=0.
- Store, zero-wait: memwrite_in=1, writedata_in=0xCAFEF00D, aluout_in=0x20 -> dmem_we=1, dmem_wdata=0xCAFEF00D, exactly 1 stall cycle, regwrite_out=0, readdata_out=0.
- Back-to-back loads to 0x10 and 0x14, ready=1 immediately -> dmem_req pattern 1,0,1 and both writebacks carry the correct destReg.
- Reset asserted mid-BUSY -> dmem_req=0 and stall_out=0 asynchronously; after release, state is IDLE and no stale writeback appears.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, dmem_ready held 0 -> mem_err pulses once after 4 BUSY cycles, regwrite_out=0, stall_out released; the next instruction proceeds normally.
